// File: rtl/tqvp_prism_infilt.sv
// ---------------------------------------------------------------------------
// tqvp_prism_infilt
//
// Glitch filter and edge-capture stage in front of the PRISM input bus.
// Each of the NBITS pin inputs only changes its clean level once it has
// disagreed with that level for more than filt_len prescaler ticks. A bypass
// mask passes selected bits through with one cycle of latency. Rising and
// falling edges of the clean levels are latched into sticky flags. Those
// flags can raise a level-sensitive interrupt.
//
// Ports
//   clk           system clock
//   rst_n         synchronous active-low reset
//   raw_in        pin inputs (already synchronised)
//   address       peripheral register address
//   data_in       write data
//   data_write_n  11 = no write, 00/01/10 = 8/16/32-bit write
//   rd_data       read data for the current address (combinational)
//   filt_out      filtered levels
//   edge_irq      edge interrupt (level)
//
// Registers
//   0x30 CFG    [3:0] filt_len, [15:8] prescale, [22:16] bypass,
//               [30:24] irq_en (32-bit writes only)
//   0x34 STATUS [6:0] rise, [14:8] fall. Any write clears the flags whose
//               data_in bit is 1. A new edge in the same cycle wins.
//   0x38 LEVELS [6:0] raw_in, [14:8] filt_out (read only)
// ---------------------------------------------------------------------------
module tqvp_prism_infilt #(
    parameter int NBITS = 7,
    parameter int CNT_W = 4,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBITS-1:0] raw_in,
    input  logic [5:0]       address,
    input  logic [31:0]      data_in,
    input  logic [1:0]       data_write_n,
    output logic [31:0]      rd_data,
    output logic [NBITS-1:0] filt_out,
    output logic             edge_irq
);

    localparam logic [5:0] ADDR_CFG    = 6'h30;
    localparam logic [5:0] ADDR_STATUS = 6'h34;
    localparam logic [5:0] ADDR_LEVELS = 6'h38;

    // Configuration
    logic [CNT_W-1:0] filt_len_reg;
    logic [PRE_W-1:0] prescale_reg;
    logic [NBITS-1:0] bypass_reg;
    logic [NBITS-1:0] irq_en_reg;

    // Filter state
    logic [PRE_W-1:0] pre_cnt_reg;
    logic [NBITS-1:0] s_reg;
    logic [NBITS-1:0] s_next;
    logic [CNT_W-1:0] c_reg  [NBITS];
    logic [CNT_W-1:0] c_next [NBITS];

    // Edge flags
    logic [NBITS-1:0] rise_reg;
    logic [NBITS-1:0] fall_reg;

    logic cfg_we;
    logic status_we;
    logic tick;

    assign cfg_we    = (address == ADDR_CFG) && (data_write_n == 2'b10);
    assign status_we = (address == ADDR_STATUS) && (data_write_n != 2'b11);
    assign tick      = (pre_cnt_reg == prescale_reg);

    // Some data_in bits have no register field behind them.
    logic unused_data;
    assign unused_data = ^{data_in[7:4], data_in[23], data_in[31]};

    // ------------------------------------------------------------------
    // Configuration register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_len_reg <= '0;
            prescale_reg <= '0;
            bypass_reg   <= '0;
            irq_en_reg   <= '0;
        end else if (cfg_we) begin
            filt_len_reg <= data_in[CNT_W-1:0];
            prescale_reg <= data_in[8 +: PRE_W];
            bypass_reg   <= data_in[16 +: NBITS];
            irq_en_reg   <= data_in[24 +: NBITS];
        end
    end

    // ------------------------------------------------------------------
    // Shared prescaler. The >= compare also catches a freshly written
    // prescale that is below the running count. That pulls the count back
    // to zero instead of letting it wrap through the full range.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt_reg <= '0;
        end else if (pre_cnt_reg >= prescale_reg) begin
            pre_cnt_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit stability filters
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NBITS; gi++) begin : g_filt
            always_comb begin
                s_next[gi] = s_reg[gi];
                c_next[gi] = c_reg[gi];
                if (bypass_reg[gi]) begin
                    s_next[gi] = raw_in[gi];
                    c_next[gi] = '0;
                end else if (raw_in[gi] == s_reg[gi]) begin
                    c_next[gi] = '0;
                end else if (tick) begin
                    // >= lets a shrunk filt_len expire on the next tick
                    if (c_reg[gi] >= filt_len_reg) begin
                        s_next[gi] = raw_in[gi];
                        c_next[gi] = '0;
                    end else begin
                        c_next[gi] = c_reg[gi] + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s_reg[gi] <= 1'b0;
                    c_reg[gi] <= '0;
                end else begin
                    s_reg[gi] <= s_next[gi];
                    c_reg[gi] <= c_next[gi];
                end
            end

            // Sticky edge flags. A set in the same cycle as its clear wins.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rise_reg[gi] <= 1'b0;
                    fall_reg[gi] <= 1'b0;
                end else begin
                    if (s_next[gi] && !s_reg[gi]) begin
                        rise_reg[gi] <= 1'b1;
                    end else if (status_we && data_in[gi]) begin
                        rise_reg[gi] <= 1'b0;
                    end
                    if (!s_next[gi] && s_reg[gi]) begin
                        fall_reg[gi] <= 1'b1;
                    end else if (status_we && data_in[8 + gi]) begin
                        fall_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign filt_out = s_reg;
    assign edge_irq = |((rise_reg | fall_reg) & irq_en_reg);

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        case (address)
            ADDR_CFG: begin
                rd_data[CNT_W-1:0]  = filt_len_reg;
                rd_data[8 +: PRE_W] = prescale_reg;
                rd_data[16 +: NBITS] = bypass_reg;
                rd_data[24 +: NBITS] = irq_en_reg;
            end
            ADDR_STATUS: begin
                rd_data[0 +: NBITS] = rise_reg;
                rd_data[8 +: NBITS] = fall_reg;
            end
            ADDR_LEVELS: begin
                rd_data[0 +: NBITS] = raw_in;
                rd_data[8 +: NBITS] = s_reg;
            end
            default: rd_data = '0;
        endcase
    end

endmodule
